// File: rtl/adder_pkg.sv
// KGP encodings, prefix-level arithmetic and pipeline depth derivation for the prefix adder.
// No state; helpers are evaluated at elaboration time.
package adder_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_G = 2'b11;
  localparam kgp_t KGP_P = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One operand-capture stage plus enough stages to cover every prefix level.
  function automatic int calc_nstg(input int width, input int lvl_per_stg);
    return 1 + (clog2(width + 1) + lvl_per_stg - 1) / lvl_per_stg;
  endfunction

endpackage

// File: rtl/kgp_rd_cell.sv
// Kogge-Stone prefix node: a propagating high span defers to the low span.
// Purely combinational, no handshake.
module kgp_rd_cell
  import adder_pkg::*;
(
  input  kgp_t high,
  input  kgp_t low,
  output kgp_t res
);

  assign res = (high == KGP_P) ? low : high;

endmodule

// File: rtl/kgp_prefix_adder_pipe.sv
// Pipelined Kogge-Stone KGP adder/subtractor; result valid NSTG-1 edges after acceptance.
// Backpressure: out_ready low freezes every stage and drops in_ready; bubbles travel with data.
module kgp_prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LVL_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L    = clog2(WIDTH + 1);
  localparam int NSTG = calc_nstg(WIDTH, LVL_PER_STG);
  localparam int NMID = NSTG - 1;

  typedef kgp_t [WIDTH:0] kvec_t;

  typedef struct packed {
    logic [WIDTH-1:0] hx;
    logic             msb_same;
    logic             a_msb;
  } side_t;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  kvec_t            kgp_in;
  side_t            side_in;

  logic [NMID-1:0]  vld_q;
  kvec_t            pf_q   [NMID];
  side_t            side_q [NMID];
  kvec_t            pf_res [NMID];

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  // Position 0 carries c0; positions 1..WIDTH hold the operand bits.
  always_comb begin
    kgp_in    = '0;
    kgp_in[0] = c0 ? KGP_G : KGP_K;
    for (int i = 0; i < WIDTH; i++) begin
      kgp_in[i+1] = {a[i] | b_eff[i], a[i] & b_eff[i]};
    end
  end

  always_comb begin
    side_in          = '0;
    side_in.hx       = a ^ b_eff;
    side_in.msb_same = (a[WIDTH-1] == b_eff[WIDTH-1]);
    side_in.a_msb    = a[WIDTH-1];
  end

  // Stage r applies levels r*LVL_PER_STG onward; levels beyond L pass straight through.
  for (genvar r = 0; r < NMID; r++) begin : g_stg
    for (genvar m = 0; m <= LVL_PER_STG; m++) begin : g_lvl
      kvec_t v;
      if (m == 0) begin : g_src
        assign v = pf_q[r];
      end else begin : g_red
        localparam int J = r * LVL_PER_STG + m - 1;
        for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
          if (J < L && i >= (1 << J)) begin : g_cell
            kgp_rd_cell u_cell (
              .high (g_lvl[m-1].v[i]),
              .low  (g_lvl[m-1].v[i-(1<<J)]),
              .res  (v[i])
            );
          end else begin : g_pass
            assign v[i] = g_lvl[m-1].v[i];
          end
        end
      end
    end
    assign pf_res[r] = g_lvl[LVL_PER_STG].v;
  end

  // Fully resolved prefixes are G or K only: G means a carry into that bit.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = side_q[NMID-1].hx[i] ^ (pf_res[NMID-1][i] == KGP_G);
    end
    cout_d = (pf_res[NMID-1][WIDTH] == KGP_G);
    ovf_d  = side_q[NMID-1].msb_same & (sum_d[WIDTH-1] != side_q[NMID-1].a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      for (int r = 0; r < NMID; r++) begin
        pf_q[r]   <= '0;
        side_q[r] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      vld_q[0]  <= in_valid;
      pf_q[0]   <= kgp_in;
      side_q[0] <= side_in;
      for (int r = 1; r < NMID; r++) begin
        vld_q[r]  <= vld_q[r-1];
        pf_q[r]   <= pf_res[r-1];
        side_q[r] <= side_q[r-1];
      end
      out_valid <= vld_q[NMID-1];
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_kgp_prefix_adder_pipe.sv
// Bench for kgp_prefix_adder_pipe: three configurations checked against an arithmetic model.
// Covers reset, directed vectors, stall/hold, mid-flight reset, exhaustive 5-bit and random 32-bit.
module tb_kgp_prefix_adder_pipe;

  localparam int NSTG8 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, sum8;
  logic iv5, ir5, cin5, sub5, ov5, or5, co5, of5;
  logic [4:0] a5, b5, sum5;
  logic iv32, ir32, cin32, sub32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, sum32;

  kgp_prefix_adder_pipe #(.WIDTH(8), .LVL_PER_STG(2)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(co8), .ovf(of8)
  );

  kgp_prefix_adder_pipe #(.WIDTH(5), .LVL_PER_STG(1)) u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .a(a5), .b(b5),
    .cin(cin5), .sub(sub5), .out_valid(ov5), .out_ready(or5), .sum(sum5),
    .cout(co5), .ovf(of5)
  );

  kgp_prefix_adder_pipe #(.WIDTH(32), .LVL_PER_STG(3)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(co32), .ovf(of32)
  );

  task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic ordy);
    case (id)
      0: begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; or8 = ordy; end
      1: begin iv5 = v; a5 = a[4:0]; b5 = b[4:0]; cin5 = cin; sub5 = sub; or5 = ordy; end
      default: begin iv32 = v; a32 = a; b32 = b; cin32 = cin; sub32 = sub; or32 = ordy; end
    endcase
  endtask

  task automatic sample(input int id, output logic rdy, output logic vld, output logic [31:0] s,
                        output logic co, output logic of);
    case (id)
      0: begin rdy = ir8; vld = ov8; s = {24'd0, sum8}; co = co8; of = of8; end
      1: begin rdy = ir5; vld = ov5; s = {27'd0, sum5}; co = co5; of = of5; end
      default: begin rdy = ir32; vld = ov32; s = sum32; co = co32; of = of32; end
    endcase
  endtask

  // Arithmetic reference: modular sum, unsigned carry/no-borrow, signed range overflow.
  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub,
                           output logic [31:0] s, output logic co, output logic of);
    longint m, ua, ub, sa, sb, t, r;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      t  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      t  = ua + ub + longint'(cin);
      co = ((t >> w) & 1) != 0;
      r  = sa + sb + longint'(cin);
    end
    s  = 32'(t & (m - 1));
    of = (r >= m / 2) || (r < -(m / 2));
  endtask

  task automatic test_reset();
    logic rdy, vld, co, of;
    logic [31:0] s;
    for (int id = 0; id < 3; id++) begin
      sample(id, rdy, vld, s, co, of);
      tests++;
      if (rdy !== 1'b1 || vld !== 1'b0 || s !== 32'd0 || co !== 1'b0 || of !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
                 id, rdy, vld, s, co, of);
      end
    end
  endtask

  task automatic send8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    logic rdy, vld, co, of;
    logic [31:0] s;
    int k;
    @(posedge clk); #1;
    drive(0, 1'b1, 32'(a), 32'(b), cin, sub, 1'b1);
    @(negedge clk);
    sample(0, rdy, vld, s, co, of);
    tests++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: in_ready=%b want 1", tag, rdy);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    k = 0;
    sample(0, rdy, vld, s, co, of);
    while (vld !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
      sample(0, rdy, vld, s, co, of);
    end
    tests++;
    if (k != NSTG8 - 1) begin
      fails++;
      $display("FAIL %s latency: %0d edges after acceptance, want %0d", tag, k, NSTG8 - 1);
    end
    tests++;
    if (s[7:0] !== es || co !== ec || of !== eo) begin
      fails++;
      $display("FAIL %s result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               tag, s[7:0], co, of, es, ec, eo);
    end
  endtask

  task automatic test_directed();
    send8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send8("add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    send8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    send8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic op_c [4];
    logic op_s [4];
    logic [31:0] es [$];
    logic ec [$];
    logic eo [$];
    logic rdy, vld, co, of, hv, hco, hof, ordy, mc, mo;
    logic [31:0] s, hs, ms;
    int sent, got, stall_left, cyc, extra;
    sent = 0; got = 0; stall_left = -1; cyc = 0; extra = 0;
    hv = 1'b0; hco = 1'b0; hof = 1'b0; hs = '0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = $urandom & 32'hFF;
      op_b[i] = $urandom & 32'hFF;
      op_c[i] = 1'($urandom);
      op_s[i] = 1'($urandom);
    end
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      if (stall_left < 0 && ov8 === 1'b1) stall_left = 3;
      ordy = !(stall_left > 0);
      if (sent < 4) drive(0, 1'b1, op_a[sent], op_b[sent], op_c[sent], op_s[sent], ordy);
      else          drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy);
      @(negedge clk);
      sample(0, rdy, vld, s, co, of);
      if (stall_left > 0) begin
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL b2b_in_ready: in_ready=%b during stall, want 0", rdy);
        end
        if (stall_left < 3) begin
          tests++;
          if (vld !== hv || s !== hs || co !== hco || of !== hof) begin
            fails++;
            $display("FAIL b2b_hold: out_valid=%b sum=%h cout=%b ovf=%b, want held %b %h %b %b",
                     vld, s, co, of, hv, hs, hco, hof);
          end
        end
        hv = vld; hs = s; hco = co; hof = of;
        stall_left--;
      end
      if (sent < 4 && rdy === 1'b1) begin
        ref_model(8, op_a[sent], op_b[sent], op_c[sent], op_s[sent], ms, mc, mo);
        es.push_back(ms); ec.push_back(mc); eo.push_back(mo);
        sent++;
      end
      if (vld === 1'b1 && ordy) begin
        tests++;
        if (es.size() == 0) begin
          fails++;
          $display("FAIL b2b_result: unexpected result sum=%h", s);
        end else begin
          ms = es.pop_front(); mc = ec.pop_front(); mo = eo.pop_front();
          if (s !== ms || co !== mc || of !== mo) begin
            fails++;
            $display("FAIL b2b_result[%0d]: sum=%h cout=%b ovf=%b, want %h %b %b",
                     got, s, co, of, ms, mc, mo);
          end
        end
        got++;
      end
      cyc++;
    end
    tests++;
    if (got != 4) begin
      fails++;
      $display("FAIL b2b_count: %0d results delivered, want 4", got);
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      if (ov8 === 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL b2b_dup: %0d extra results after drain, want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h55, 32'h0F, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (ov8 !== 1'b1 || sum8 !== 8'h46) begin
      fails++;
      $display("FAIL mid_rst_pre: out_valid=%b sum=%h, want 1 46", ov8, sum8);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ov8 !== 1'b0 || sum8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0 || ir8 !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst_async: out_valid=%b sum=%h cout=%b ovf=%b in_ready=%b, want 0 00 0 0 1",
               ov8, sum8, co8, of8, ir8);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      if (ov8 === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_rst_ghost: %0d results emerged after reset, want 0", seen);
    end
  endtask

  task automatic run_stream(input int id, input int w, input int n, input bit exh,
                            input int pv, input int pr, input string tag);
    logic [31:0] es [$];
    logic ec [$];
    logic eo [$];
    logic [31:0] ca, cb, s, ms, mask;
    logic ccin, csub, v, r, rdy, vld, co, of, mc, mo;
    bit have, rdy_drop;
    int sent, got, cyc, first, last, limit;
    ca = '0; cb = '0; ccin = 1'b0; csub = 1'b0;
    have = 1'b0; rdy_drop = 1'b0;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    limit = n * 8 + 200;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    while (got < n && cyc < limit) begin
      @(posedge clk); #1;
      if (!have && sent < n) begin
        if (exh) begin
          ca = 32'(sent & 31); cb = 32'((sent >> 5) & 31);
          ccin = sent[10]; csub = sent[11];
        end else begin
          ca = $urandom & mask; cb = $urandom & mask;
          ccin = 1'($urandom); csub = 1'($urandom);
        end
        have = 1'b1;
      end
      v = have && ($urandom_range(99) < pv);
      r = ($urandom_range(99) < pr);
      drive(id, v, ca, cb, ccin, csub, r);
      @(negedge clk);
      sample(id, rdy, vld, s, co, of);
      if (rdy !== 1'b1) rdy_drop = 1'b1;
      if (v && rdy === 1'b1) begin
        ref_model(w, ca, cb, ccin, csub, ms, mc, mo);
        es.push_back(ms); ec.push_back(mc); eo.push_back(mo);
        have = 1'b0;
        sent++;
      end
      if (vld === 1'b1 && r) begin
        tests++;
        if (es.size() == 0) begin
          fails++;
          $display("FAIL %s result: unexpected result sum=%h", tag, s);
        end else begin
          ms = es.pop_front(); mc = ec.pop_front(); mo = eo.pop_front();
          if (s !== ms || co !== mc || of !== mo) begin
            fails++;
            $display("FAIL %s result[%0d]: sum=%h cout=%b ovf=%b, want %h %b %b",
                     tag, got, s, co, of, ms, mc, mo);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      cyc++;
    end
    drive(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (got != n) begin
      fails++;
      $display("FAIL %s count: %0d results in %0d cycles, want %0d", tag, got, cyc, n);
    end
    if (pv == 100 && pr == 100) begin
      tests++;
      if (rdy_drop || (last - first + 1) != n) begin
        fails++;
        $display("FAIL %s throughput: %0d results over %0d cycles (ready dropped=%b), want one per cycle",
                 tag, got, last - first + 1, rdy_drop);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_exhaustive_w5();
    run_stream(1, 5, 4096, 1'b1, 60, 60, "w5_exh");
  endtask

  task automatic test_random_w32();
    run_stream(2, 32, 10000, 1'b0, 100, 100, "w32_rate");
    run_stream(2, 32, 400, 1'b0, 70, 50, "w32_hs");
  endtask

  initial begin
    for (int id = 0; id < 3; id++) drive(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_exhaustive_w5();
    test_random_w32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
